// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: PC/IR stage of the five-phase multicycle core; FETCH_PC_RETIRE_CNT_EN builds the retire counter.
module fetch_pc_unit #(
  parameter int DW = 16,
  parameter int AW = 16,
  parameter int RESET_PC = 0,
  parameter logic [4:0] HLT_OP = 5'h1F
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic [4:0]    phase,
  output logic [AW-1:0] imem_addr,
  output logic          imem_rd,
  input  logic [DW-1:0] imem_rdata,
  input  logic          br_taken,
  input  logic [AW-1:0] br_target,
  output logic [AW-1:0] pc,
  output logic [AW-1:0] npc,
  output logic [DW-1:0] ir,
  output logic          hlt,
  output logic          phase_err,
  output logic [31:0]   retired
);
  logic legal, is_hlt, retire;
  always_comb begin
    legal = (phase & (phase - 5'd1)) == 5'd0;
    is_hlt = ir[DW-1:DW-5] == HLT_OP;
    retire = legal & phase[4];
    npc = pc + AW'(1);
    imem_addr = pc;
    imem_rd = legal & phase[0];
    hlt = retire & is_hlt;
  end
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      pc <= AW'(RESET_PC);
      ir <= '0;
      phase_err <= 1'b0;
    end else if (!legal) begin
      phase_err <= 1'b1;
    end else begin
      if (phase[0]) ir <= imem_rdata;
      if (retire && !is_hlt) pc <= br_taken ? br_target : npc;
    end
  end
`ifdef FETCH_PC_RETIRE_CNT_EN
  always_ff @(posedge clk) begin
    if (!n_rst) retired <= '0;
    else if (retire) retired <= retired + 32'd1;
  end
`else
  assign retired = '0;
`endif
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed scoreboard bench for fetch_pc_unit.
module tb_fetch_pc_unit;
  localparam logic [4:0] I = 5'b00000, F = 5'b00001, R = 5'b00010, X = 5'b00100, M = 5'b01000, W = 5'b10000;
  logic clk = 0, n_rst = 0, imem_rd, br_taken = 0, hlt, phase_err;
  logic [4:0] phase = I;
  logic [15:0] imem_addr, imem_rdata = 0, br_target = 0, pc, npc, ir;
  logic [31:0] retired;
  int checks = 0, errors = 0;
  typedef struct {logic [15:0] pc, ir; logic hlt, rd, err; logic [31:0] ret;} exp_t;
  exp_t q[$];

  fetch_pc_unit dut (.clk(clk), .n_rst(n_rst), .phase(phase), .imem_addr(imem_addr), .imem_rd(imem_rd),
    .imem_rdata(imem_rdata), .br_taken(br_taken), .br_target(br_target), .pc(pc), .npc(npc), .ir(ir),
    .hlt(hlt), .phase_err(phase_err), .retired(retired));

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (q.size() > 0) begin
    exp_t e;
    e = q.pop_front();
    cmp("pc", 32'(pc), 32'(e.pc));
    cmp("imem_addr", 32'(imem_addr), 32'(e.pc));
    cmp("npc", 32'(npc), 32'(16'(e.pc + 16'd1)));
    cmp("ir", 32'(ir), 32'(e.ir));
    cmp("hlt", 32'(hlt), 32'(e.hlt));
    cmp("imem_rd", 32'(imem_rd), 32'(e.rd));
    cmp("phase_err", 32'(phase_err), 32'(e.err));
    cmp("retired", retired, e.ret);
  end

  // drive one cycle and queue the outputs expected during it (state before its closing edge)
  task automatic cyc(input logic n, input logic [4:0] ph, input logic [15:0] rd, input logic bt,
                     input logic [15:0] tgt, input logic chk, input logic [15:0] e_pc, input logic [15:0] e_ir,
                     input logic e_hlt, input logic e_err, input logic [31:0] e_ret);
    exp_t e;
    n_rst = n; phase = ph; imem_rdata = rd; br_taken = bt; br_target = tgt;
    e.pc = e_pc; e.ir = e_ir; e.hlt = e_hlt; e.err = e_err; e.rd = (ph == F);
`ifdef FETCH_PC_RETIRE_CNT_EN
    e.ret = e_ret;
`else
    e.ret = 32'd0;
`endif
    if (chk) q.push_back(e);
    @(posedge clk); #1;
  endtask

  initial begin
    @(posedge clk); #1;
    cyc(0, I, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, I, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    // plain instruction at 0
    cyc(1, F, 16'h1234, 0, 0, 1, 0, 0, 0, 0, 0);
    cyc(1, R, 0, 1, 16'h0077, 1, 0, 16'h1234, 0, 0, 0);
    cyc(1, X, 0, 1, 16'h0077, 1, 0, 16'h1234, 0, 0, 0);
    cyc(1, M, 0, 0, 0, 1, 0, 16'h1234, 0, 0, 0);
    cyc(1, W, 0, 0, 0, 1, 0, 16'h1234, 0, 0, 0);
    // taken branch to 00A0
    cyc(1, F, 16'h0001, 0, 0, 1, 1, 16'h1234, 0, 0, 1);
    cyc(1, R, 0, 0, 0, 1, 1, 16'h0001, 0, 0, 1);
    cyc(1, X, 0, 0, 0, 1, 1, 16'h0001, 0, 0, 1);
    cyc(1, M, 0, 0, 0, 1, 1, 16'h0001, 0, 0, 1);
    cyc(1, W, 0, 1, 16'h00A0, 1, 1, 16'h0001, 0, 0, 1);
    // at 00A0, branch to 5
    cyc(1, F, 16'h0002, 0, 0, 1, 16'h00A0, 16'h0001, 0, 0, 2);
    cyc(1, R, 0, 0, 0, 1, 16'h00A0, 16'h0002, 0, 0, 2);
    cyc(1, X, 0, 0, 0, 1, 16'h00A0, 16'h0002, 0, 0, 2);
    cyc(1, M, 0, 0, 0, 1, 16'h00A0, 16'h0002, 0, 0, 2);
    cyc(1, W, 0, 1, 16'h0005, 1, 16'h00A0, 16'h0002, 0, 0, 2);
    // HLT at 5, branch request in W must lose
    cyc(1, F, 16'hF800, 0, 0, 1, 5, 16'h0002, 0, 0, 3);
    cyc(1, R, 0, 0, 0, 1, 5, 16'hF800, 0, 0, 3);
    cyc(1, X, 0, 0, 0, 1, 5, 16'hF800, 0, 0, 3);
    cyc(1, M, 0, 0, 0, 1, 5, 16'hF800, 0, 0, 3);
    cyc(1, W, 0, 1, 16'h0033, 1, 5, 16'hF800, 1, 0, 3);
    cyc(1, I, 0, 0, 0, 1, 5, 16'hF800, 0, 0, 4);
    cyc(1, I, 0, 0, 0, 1, 5, 16'hF800, 0, 0, 4);
    // reset, then branch to FFFF and wrap
    cyc(0, I, 0, 0, 0, 1, 5, 16'hF800, 0, 0, 4);
    cyc(1, F, 16'h0000, 0, 0, 1, 0, 0, 0, 0, 0);
    cyc(1, R, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    cyc(1, X, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    cyc(1, M, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    cyc(1, W, 0, 1, 16'hFFFF, 1, 0, 0, 0, 0, 0);
    cyc(1, F, 16'h0003, 0, 0, 1, 16'hFFFF, 0, 0, 0, 1);
    cyc(1, R, 0, 0, 0, 1, 16'hFFFF, 16'h0003, 0, 0, 1);
    cyc(1, X, 0, 0, 0, 1, 16'hFFFF, 16'h0003, 0, 0, 1);
    cyc(1, M, 0, 0, 0, 1, 16'hFFFF, 16'h0003, 0, 0, 1);
    cyc(1, W, 0, 0, 0, 1, 16'hFFFF, 16'h0003, 0, 0, 1);
    cyc(1, I, 0, 0, 0, 1, 0, 16'h0003, 0, 0, 2);
    // illegal phase with F and R bits set: nothing but phase_err moves
    cyc(1, 5'b00011, 16'hAAAA, 1, 16'h0055, 1, 0, 16'h0003, 0, 0, 2);
    cyc(1, 5'b10001, 16'hBBBB, 1, 16'h0055, 1, 0, 16'h0003, 0, 1, 2);
    cyc(1, I, 0, 0, 0, 1, 0, 16'h0003, 0, 1, 2);
    // self-loop branch at 0
    cyc(1, F, 16'h0004, 0, 0, 1, 0, 16'h0003, 0, 1, 2);
    cyc(1, R, 0, 0, 0, 1, 0, 16'h0004, 0, 1, 2);
    cyc(1, X, 0, 0, 0, 1, 0, 16'h0004, 0, 1, 2);
    cyc(1, M, 0, 0, 0, 1, 0, 16'h0004, 0, 1, 2);
    cyc(1, W, 0, 1, 16'h0000, 1, 0, 16'h0004, 0, 1, 2);
    // branch to 7, then reset in X of the instruction at 7
    cyc(1, F, 16'h0005, 0, 0, 1, 0, 16'h0004, 0, 1, 3);
    cyc(1, R, 0, 0, 0, 1, 0, 16'h0005, 0, 1, 3);
    cyc(1, X, 0, 0, 0, 1, 0, 16'h0005, 0, 1, 3);
    cyc(1, M, 0, 0, 0, 1, 0, 16'h0005, 0, 1, 3);
    cyc(1, W, 0, 1, 16'h0007, 1, 0, 16'h0005, 0, 1, 3);
    cyc(1, F, 16'h0006, 0, 0, 1, 7, 16'h0005, 0, 1, 4);
    cyc(1, R, 0, 0, 0, 1, 7, 16'h0006, 0, 1, 4);
    cyc(0, X, 0, 0, 0, 1, 7, 16'h0006, 0, 1, 4);
    cyc(1, I, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    cyc(1, I, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain actual=%0d expected=0 entries left", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
